serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
Serial frame transmitter that sits directly upstream of the frame receiver. It accepts one parallel word per valid/ready handshake and serializes it onto a single line: start bit, data bits LSB first, then stop bit. Each bit is held for CLKS_PER_BIT clocks. It drives the receiver's start strobe and serial data input, and it can deliberately corrupt the stop bit so the receiver's frame-error path can be exercised.

Parameters:
DATA_WIDTH, 4, number of data bits per frame (>=1)
CLKS_PER_BIT, 5, clocks each bit is held on the line (>=2)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
tx_valid  input  1  upstream has a word to send
tx_data  input  DATA_WIDTH  word to send; sampled only on handshake
inject_err  input  1  sampled with tx_data; 1 = send stop bit as 0
tx_ready  output  1  block can accept a word (high only in IDLE)
tx_start  output  1  one-cycle pulse on first cycle of start bit; feeds receiver rx_start
serial_out  output  1  serial line; idle level 1; feeds receiver data_in
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse on last cycle of stop bit

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE, serial_out=1, tx_ready=1, tx_start=0, busy=0, frame_done=0, counters=0, data/err latches=0.
- Handshake: the word is accepted on the rising edge where tx_valid && tx_ready.
  - tx_data and inject_err are latched at that edge; later changes are ignored until the next accept.
  - tx_ready is a function of state only, with no combinational path from tx_valid.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: serial_out=1, tx_ready=1. On accept, go to START.
  - START: serial_out=0 for CLKS_PER_BIT cycles. tx_start=1 only in the first of these cycles.
  - DATA: bit i (i=0..DATA_WIDTH-1, LSB first) is driven for CLKS_PER_BIT cycles each, then go to STOP.
  - STOP: serial_out = ~err_latched for CLKS_PER_BIT cycles. frame_done=1 in the last cycle, then go to IDLE.
- Timing:
  - clk_cnt runs 0..CLKS_PER_BIT-1. bit_tick = (clk_cnt==CLKS_PER_BIT-1). clk_cnt wraps to 0 on bit_tick.
  - bit_cnt counts data bits and advances on bit_tick while in DATA.
  - Counter widths are $clog2 of their ranges; no overflow is possible.
  - Latency: serial_out falls on the first cycle after the accept edge.
  - Frame length is exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles from the START entry to the IDLE entry.
- Back-to-back frames: tx_ready is 0 during the frame_done cycle. A word that is held valid is accepted in the following IDLE cycle. Minimum inter-frame gap is 1 cycle of serial_out=1.
- All outputs are registered or decoded from state/counters only; serial_out is glitch-free (registered).
- Reset mid-frame: at the next edge the block returns to IDLE with serial_out=1. The partial frame is dropped and no frame_done is issued.
- tx_valid without tx_ready (mid-frame) has no effect; the upstream must hold tx_valid until accepted.

Decomposition:
- Shared package holds:
  - state enum (IDLE, START, DATA, STOP), 2-bit encoding;
  - localparam FRAME_CYCLES = (DATA_WIDTH+2)*CLKS_PER_BIT;
  - line-level constants LINE_IDLE=1, START_LVL=0, STOP_LVL=1.
- One sub-module, bit_timer: clk_cnt with clear/enable and a bit_tick output, parameterised by CLKS_PER_BIT.
- The FSM, bit counter and data shift register stay in serial_frame_tx.

Test Plan:
1. Reset release, then tx_data=4'b1010, tx_valid=1, inject_err=0 (DATA_WIDTH=4, CLKS_PER_BIT=5) -> required response:
   - serial_out = 0×5, 0×5, 1×5, 0×5, 1×5, 1×5;
   - tx_start high only in cycle 1 after accept;
   - frame_done in cycle 30; tx_ready back at cycle 31.
2. Same word with inject_err=1 -> identical line except the stop bit is 0×5. A connected receiver asserts frame_error; a clean frame asserts no frame_error.
3. tx_valid held high with words 4'h3 then 4'hC -> second accept occurs exactly 1 cycle after frame_done, with exactly one idle cycle of serial_out=1 between frames.
4. tx_data changed to 4'hF while busy, tx_valid pulsed mid-frame -> transmitted bits match the latched word; no extra frame starts; tx_ready stays 0.
5. reset asserted during the DATA state -> next edge gives serial_out=1, busy=0, tx_ready=1, and no frame_done. A new word is then sent correctly from START.
6. Parameter sweep (DATA_WIDTH=1, CLKS_PER_BIT=2; DATA_WIDTH=8, CLKS_PER_BIT=16) -> frame length equals FRAME_CYCLES, and data appears LSB first.

Source files
------------

// File: rtl/serial_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx_pkg
// Description : Shared state encoding, line levels and frame-length helper
//               for the serial frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_frame_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEF_DATA_WIDTH   = 4;
    localparam int DEF_CLKS_PER_BIT = 5;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Start bit + data bits + stop bit, each held for cpb clocks.
    function automatic int frame_cycles(input int dw, input int cpb);
        return (dw + 2) * cpb;
    endfunction

    localparam int FRAME_CYCLES = frame_cycles(DEF_DATA_WIDTH, DEF_CLKS_PER_BIT);

endpackage : serial_frame_tx_pkg
`default_nettype wire

// File: rtl/serial_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx_if
// Description : Word handshake and serial-line signals of the frame
//               transmitter; master = upstream word source, slave = transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_frame_tx_if #(
    parameter int DATA_WIDTH = 4
) ();

    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  inject_err;
    logic                  tx_ready;
    logic                  tx_start;
    logic                  serial_out;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output tx_valid,
        output tx_data,
        output inject_err,
        input  tx_ready,
        input  tx_start,
        input  serial_out,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  inject_err,
        output tx_ready,
        output tx_start,
        output serial_out,
        output busy,
        output frame_done
    );

endinterface : serial_frame_tx_if
`default_nettype wire

// File: rtl/serial_frame_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx_bit_timer
// Description : Per-bit clock counter; flags the last clock of each bit and
//               the clock just before it.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 5
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_bit_tick,
    output logic      o_pre_tick
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_PRE  = c_CNT_W'(CLKS_PER_BIT - 2);

    logic [c_CNT_W-1:0] r_clk_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_clk_cnt <= '0;
        end else if (i_enable) begin
            if (r_clk_cnt == c_LAST) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
        end
    end

    // Pre-tick lets the parent register a pulse that lands on the last clock.
    assign o_bit_tick = i_enable && (r_clk_cnt == c_LAST);
    assign o_pre_tick = i_enable && (r_clk_cnt == c_PRE);

endmodule : serial_frame_tx_bit_timer
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx
// Description : Serializes one word per handshake as start/data(LSB first)/stop
//               bits, with optional stop-bit corruption for error testing.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  wire logic         clk,
    input  wire logic         reset,
    serial_frame_tx_if.slave  bus
);

    localparam int c_BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic                  r_err;
    logic                  r_serial;
    logic                  r_ready;
    logic                  r_start;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_in_idle;
    logic                  w_bit_tick;
    logic                  w_pre_tick;

    assign w_in_idle = (r_state == IDLE);

    serial_frame_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_in_idle),
        .i_enable   (!w_in_idle),
        .o_bit_tick (w_bit_tick),
        .o_pre_tick (w_pre_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_err     <= 1'b0;
            r_serial  <= LINE_IDLE;
            r_ready   <= 1'b1;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.tx_valid && r_ready) begin
                        r_shift   <= bus.tx_data;
                        r_err     <= bus.inject_err;
                        r_bit_cnt <= '0;
                        r_serial  <= START_LVL;
                        r_start   <= 1'b1;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_bit_tick) begin
                        r_serial <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_state  <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_cnt == c_LAST_BIT) begin
                            // A latched error request flips only the stop level.
                            r_serial <= r_err ? ~STOP_LVL : STOP_LVL;
                            r_state  <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_serial  <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                STOP: begin
                    if (w_pre_tick) begin
                        r_done <= 1'b1;
                    end
                    if (w_bit_tick) begin
                        r_serial <= LINE_IDLE;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.serial_out = r_serial;
    assign bus.tx_ready   = r_ready;
    assign bus.tx_start   = r_start;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;

endmodule : serial_frame_tx
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_tx
// Description : Self-checking bench for serial_frame_tx at three parameter
//               points, compared against a bit-slot model of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] valid_a = '0;
    logic [2:0] err_a   = '0;
    logic [7:0] data_a [3];
    logic [2:0] so_a, ready_a, start_a, busy_a, done_a;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic int dw_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 8;
    endfunction

    function automatic int cpb_of(input int k);
        return (k == 0) ? 5 : (k == 1) ? 2 : 16;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int DW  = (k == 0) ? 4 : (k == 1) ? 1 : 8;
        localparam int CPB = (k == 0) ? 5 : (k == 1) ? 2 : 16;

        serial_frame_tx_if #(.DATA_WIDTH(DW)) u_if ();

        assign u_if.tx_valid   = valid_a[k];
        assign u_if.tx_data    = data_a[k][DW-1:0];
        assign u_if.inject_err = err_a[k];
        assign so_a[k]         = u_if.serial_out;
        assign ready_a[k]      = u_if.tx_ready;
        assign start_a[k]      = u_if.tx_start;
        assign busy_a[k]       = u_if.busy;
        assign done_a[k]       = u_if.frame_done;

        serial_frame_tx #(
            .DATA_WIDTH   (DW),
            .CLKS_PER_BIT (CPB)
        ) u_dut (
            .clk   (clk),
            .reset (rst),
            .bus   (u_if.slave)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level in cycle c (1-based from the accept edge): slot 0 is the
    // start bit, slots 1..dw the data bits, the final slot the stop bit.
    function automatic logic exp_bit(input int k, input logic [7:0] w, input logic e, input int c);
        int slot;
        slot = (c - 1) / cpb_of(k);
        if (slot == 0) return 1'b0;
        if (slot <= dw_of(k)) return w[slot-1];
        return ~e;
    endfunction

    // Idle-state output pattern {serial_out, tx_ready, tx_start, busy, frame_done}.
    function automatic logic [4:0] idle_vec(input int k);
        return {so_a[k], ready_a[k], start_a[k], busy_a[k], done_a[k]};
    endfunction

    // Called at the falling edge of cycle 1 after an accept; returns at cycle F+1.
    task automatic capture_frame(input int k, input logic [7:0] w, input logic e,
                                 input bit poke, input string tag);
        int   f, cpb;
        int   bad_line, start_cnt, start_at, done_cnt, done_at, ready_hi, busy_lo;
        logic stop_mid;
        cpb = cpb_of(k);
        f = (dw_of(k) + 2) * cpb;
        bad_line = 0; start_cnt = 0; start_at = 0; done_cnt = 0; done_at = 0;
        ready_hi = 0; busy_lo = 0; stop_mid = 1'bx;
        for (int c = 1; c <= f; c++) begin
            if (so_a[k] !== exp_bit(k, w, e, c)) bad_line++;
            if (start_a[k] === 1'b1) begin start_cnt++; start_at = c; end
            if (done_a[k] === 1'b1)  begin done_cnt++;  done_at = c;  end
            if (ready_a[k] !== 1'b0) ready_hi++;
            if (busy_a[k] !== 1'b1)  busy_lo++;
            if (c == f - cpb / 2) stop_mid = so_a[k];
            if (poke && c == f / 2)     begin valid_a[k] = 1'b1; data_a[k] = 8'hFF; end
            if (poke && c == f / 2 + 1) valid_a[k] = 1'b0;
            @(negedge clk);
        end
        chk($sformatf("%s line_errs", tag), bad_line, 0);
        chk($sformatf("%s start_cnt_at", tag), {start_cnt[15:0], start_at[15:0]}, {16'd1, 16'd1});
        chk($sformatf("%s done_cnt_at", tag), {done_cnt[15:0], done_at[15:0]}, {16'd1, f[15:0]});
        chk($sformatf("%s ready_busy_during", tag), {ready_hi[15:0], busy_lo[15:0]}, 32'd0);
        chk($sformatf("%s frame_error", tag), {31'd0, (stop_mid === 1'b0)}, {31'd0, e});
        chk($sformatf("%s after_frame", tag), {27'd0, idle_vec(k)}, {27'd0, 5'b11000});
    endtask

    task automatic send(input int k, input logic [7:0] w, input logic e,
                        input bit hold, input logic [7:0] w_next, input bit poke,
                        input string tag);
        valid_a[k] = 1'b1;
        data_a[k]  = w;
        err_a[k]   = e;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            data_a[k] = w_next;
            err_a[k]  = 1'b0;
        end else begin
            valid_a[k] = 1'b0;
            data_a[k]  = 8'($urandom);
            err_a[k]   = 1'($urandom);
        end
        capture_frame(k, w, e, poke, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         quiet_bad;
        logic [7:0] w;
        logic       e;
        for (int k = 0; k < 3; k++) data_a[k] = 8'h00;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("reset_state%0d", k), {27'd0, idle_vec(k)}, {27'd0, 5'b11000});
        rst = 1'b0;
        @(negedge clk);

        send(0, 8'h0A, 1'b0, 1'b0, 8'h00, 1'b0, "t1_clean");
        send(0, 8'h0A, 1'b1, 1'b0, 8'h00, 1'b0, "t2_err");

        // Back-to-back: valid held, second word accepted in the first idle cycle.
        send(0, 8'h03, 1'b0, 1'b1, 8'h0C, 1'b0, "t3_first");
        @(posedge clk);
        @(negedge clk);
        valid_a[0] = 1'b0;
        capture_frame(0, 8'h0C, 1'b0, 1'b0, "t3_second");

        send(0, 8'h05, 1'b0, 1'b0, 8'h00, 1'b1, "t4_poke");
        quiet_bad = 0;
        repeat (8) begin
            if (idle_vec(0) !== 5'b11000) quiet_bad++;
            @(negedge clk);
        end
        chk("t4_no_extra_frame", quiet_bad, 0);

        // Reset during DATA: frame dropped, no frame_done afterwards.
        valid_a[0] = 1'b1; data_a[0] = 8'h09; err_a[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        valid_a[0] = 1'b0;
        repeat (11) @(negedge clk);
        chk("t5_busy_in_data", {31'd0, busy_a[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_after_reset", {27'd0, idle_vec(0)}, {27'd0, 5'b11000});
        rst = 1'b0;
        quiet_bad = 0;
        repeat (30) begin
            if (idle_vec(0) !== 5'b11000) quiet_bad++;
            @(negedge clk);
        end
        chk("t5_quiet_after_reset", quiet_bad, 0);
        send(0, 8'h06, 1'b0, 1'b0, 8'h00, 1'b0, "t5_resend");

        send(1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, "t6_n_one");
        send(1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "t6_n_zero_err");
        send(2, 8'hB4, 1'b0, 1'b0, 8'h00, 1'b0, "t6_w_b4");

        for (int i = 0; i < 9; i++) begin
            w = 8'($urandom);
            e = 1'($urandom_range(0, 3) == 0);
            send(i % 3, w, e, 1'b0, 8'h00, 1'b0, $sformatf("rnd%0d_k%0d_w%02h", i, i % 3, w));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_frame_tx
`default_nettype wire
